// File: rtl/ad1_acq_ctrl.sv
// ad1_acq_ctrl: paces conversion starts for a two-channel AD1 SPI capture
// engine, averages 2^AVG_LOG2 conversions per channel, and buffers the
// averaged pairs in a first-word-fall-through FIFO with valid/ready output.
// Ports:
//   clk, rst (async, active-low)
//   enable, flush, clr_err      : control inputs
//   start / busy, drdy, din0/1  : SPI engine handshake and data (bits [11:0] used)
//   m_valid, m_ready, m_data0/1 : FIFO head (m_valid/m_data decoded from FIFO state)
//   level                       : FIFO occupancy
//   err_late, err_ovf           : sticky error flags
module ad1_acq_ctrl #(
  parameter int unsigned SAMPLE_PERIOD   = 100,
  parameter int unsigned AVG_LOG2        = 2,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     clr_err,
  output logic                     start,
  input  logic                     busy,
  input  logic                     drdy,
  input  logic [15:0]              din0,
  input  logic [15:0]              din1,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [11:0]              m_data0,
  output logic [11:0]              m_data1,
  output logic [FIFO_DEPTH_LOG2:0] level,
  output logic                     err_late,
  output logic                     err_ovf
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_PERIOD);
  localparam int unsigned ACC_W = 12 + AVG_LOG2;
  localparam int unsigned AVG_N = 1 << AVG_LOG2;
  localparam int unsigned AVG_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;
  localparam int unsigned LVL_W = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, WAIT_TICK, START, WAIT_DRDY} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic               take;
  logic               late_set;
  logic [ACC_W-1:0]   acc0, acc1;
  logic [ACC_W-1:0]   sum0, sum1;
  logic [AVG_W-1:0]   avg_cnt;
  logic               push;
  logic [23:0]        push_pair;
  logic [23:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               full, pop, wr_en, ovf_set;
  logic               unused_din;

  assign unused_din = ^{din0[15:12], din1[15:12]};

  // Sample period counter, held at zero while idle
  assign tick = (cnt == CNT_W'(SAMPLE_PERIOD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      cnt <= '0;
    else if (state == IDLE || tick) cnt <= '0;
    else                           cnt <= cnt + CNT_W'(1);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state; an outstanding conversion always completes before idling
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    late_set  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (busy) late_set  = 1'b1;
          else      state_nxt = START;
        end
      end
      START: begin
        late_set  = tick;
        state_nxt = WAIT_DRDY;
      end
      WAIT_DRDY: begin
        late_set = tick;
        if (drdy) begin
          take      = 1'b1;
          state_nxt = enable ? WAIT_TICK : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Start pulse is the registered image of the START state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) start <= 1'b0;
    else      start <= (state == START);
  end

  // Averaging: final conversion of a block is pushed straight from the adder
  assign sum0      = acc0 + ACC_W'(din0[11:0]);
  assign sum1      = acc1 + ACC_W'(din1[11:0]);
  assign push      = take && (avg_cnt == AVG_W'(AVG_N - 1));
  assign push_pair = {12'(sum0 >> AVG_LOG2), 12'(sum1 >> AVG_LOG2)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc0    <= '0;
      acc1    <= '0;
      avg_cnt <= '0;
    end else if (state == IDLE || push) begin
      acc0    <= '0;
      acc1    <= '0;
      avg_cnt <= '0;
    end else if (take) begin
      acc0    <= sum0;
      acc1    <= sum1;
      avg_cnt <= avg_cnt + AVG_W'(1);
    end
  end

  // FIFO control; a pop frees the slot a same-cycle push needs when full
  assign full    = (level == LVL_W'(DEPTH));
  assign m_valid = (level != '0);
  assign pop     = m_valid && m_ready;
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop && !flush;

  assign {m_data0, m_data1} = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage, cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wr_en && !flush) begin
      mem[wr_ptr] <= push_pair;
    end
  end

  // Sticky errors; a same-cycle set beats clr_err
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_late <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      err_late <= late_set | (err_late & ~clr_err);
      err_ovf  <= ovf_set  | (err_ovf  & ~clr_err);
    end
  end

endmodule

// File: tb/tb_ad1_acq_ctrl.sv
// tb_ad1_acq_ctrl: drives ad1_acq_ctrl with a behavioural SPI engine model
// and checks it against a queue-based reference of the averaging FIFO.
module tb_ad1_acq_ctrl;

  localparam int unsigned P     = 40;
  localparam int unsigned AL    = 2;
  localparam int unsigned FL    = 3;
  localparam int          AVG_N = 1 << AL;
  localparam int          DEPTH = 1 << FL;

  logic        clk = 1'b0;
  logic        rst, enable, flush, clr_err, start, busy, drdy;
  logic [15:0] din0, din1;
  logic        m_valid, m_ready;
  logic [11:0] m_data0, m_data1;
  logic [FL:0] level;
  logic        err_late, err_ovf;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int eng_lat  = 20;
  bit model_take = 1'b1;

  logic [31:0] din_q [$];      // directed {din0,din1} words for the engine
  int          start_cyc [$];  // cycle stamps of observed start pulses
  logic [23:0] exp_q [$];      // expected FIFO contents
  int          g0 [$], g1 [$]; // conversions of the current average block
  int          n_avg   = 0;
  bit          exp_ovf = 1'b0;

  ad1_acq_ctrl #(.SAMPLE_PERIOD(P), .AVG_LOG2(AL), .FIFO_DEPTH_LOG2(FL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .clr_err(clr_err),
    .start(start), .busy(busy), .drdy(drdy), .din0(din0), .din1(din1),
    .m_valid(m_valid), .m_ready(m_ready), .m_data0(m_data0), .m_data1(m_data1),
    .level(level), .err_late(err_late), .err_ovf(err_ovf)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // SPI engine: busy from start until drdy, eng_lat cycles later
  initial begin
    busy = 1'b0; drdy = 1'b0; din0 = '0; din1 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (start === 1'b1) begin
        start_cyc.push_back(cyc);
        busy = 1'b1;
        repeat (eng_lat) @(posedge clk);
        #1;
        if (din_q.size() != 0) {din0, din1} = din_q.pop_front();
        else begin
          din0 = 16'($urandom);
          din1 = 16'($urandom);
        end
        drdy = 1'b1;
        busy = 1'b0;
        @(posedge clk);
        #1;
        drdy = 1'b0;
      end
    end
  end

  // Reference: block averages of accepted conversions into a bounded queue
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      exp_q.delete(); g0.delete(); g1.delete();
      exp_ovf = 1'b0;
    end else begin
      bit          pop_m, push_m, ovf_m;
      int          s0, s1;
      logic [23:0] pair;
      pop_m = m_ready && (exp_q.size() != 0);
      push_m = 1'b0;
      ovf_m  = 1'b0;
      pair   = '0;
      if (drdy && model_take) begin
        g0.push_back(int'(din0[11:0]));
        g1.push_back(int'(din1[11:0]));
        if (g0.size() == AVG_N) begin
          s0 = 0; s1 = 0;
          foreach (g0[i]) begin s0 += g0[i]; s1 += g1[i]; end
          pair   = {12'(s0 / AVG_N), 12'(s1 / AVG_N)};
          push_m = 1'b1;
          n_avg++;
          g0.delete(); g1.delete();
        end else if (!enable) begin
          g0.delete(); g1.delete();
        end
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (pop_m) void'(exp_q.pop_front());
        if (push_m) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(pair);
          else ovf_m = 1'b1;
        end
      end
      exp_ovf = ovf_m | (exp_ovf & !clr_err);
    end
  end

  // Every cycle: FIFO view and overflow flag against the reference
  initial forever begin
    @(posedge clk);
    #3;
    chk("level", 32'(level), 32'(exp_q.size()));
    chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("head0", 32'(m_data0), 32'(exp_q[0][23:12]));
      chk("head1", 32'(m_data1), 32'(exp_q[0][11:0]));
    end
    chk("err_ovf", 32'(err_ovf), 32'(exp_ovf));
  end

  initial begin
    int n, to, base, k, k2;
    rst = 1'b0; enable = 1'b0; flush = 1'b0; clr_err = 1'b0; m_ready = 1'b0;
    repeat (3) step();
    chk("rst_start", 32'(start), 32'(0));
    chk("rst_m_valid", 32'(m_valid), 32'(0));
    chk("rst_m_data0", 32'(m_data0), 32'(0));
    chk("rst_m_data1", 32'(m_data1), 32'(0));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_err_late", 32'(err_late), 32'(0));
    chk("rst_err_ovf", 32'(err_ovf), 32'(0));
    rst = 1'b1;
    step();

    // Directed blocks: constant pair, then 10,11,12,14 / 20,21,22,23
    repeat (4) din_q.push_back({16'h0ABC, 16'h0123});
    din_q.push_back({16'd10, 16'd20});
    din_q.push_back({16'd11, 16'd21});
    din_q.push_back({16'd12, 16'd22});
    din_q.push_back({16'd14, 16'd23});
    enable = 1'b1;
    n = 0;
    do begin step(); n++; end while (start !== 1'b1 && n < 200);
    chk("first_start_latency", 32'(n), 32'(P + 2));

    to = 0;
    while (exp_q.size() < 2 && to < 1000) begin step(); to++; end
    chk("wait_two_entries", 32'(to < 1000), 32'(1));
    chk("entry0_ch0", 32'(m_data0), 32'(12'hABC));
    chk("entry0_ch1", 32'(m_data1), 32'(12'h123));
    chk("two_level", 32'(level), 32'(2));
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("avg_ch0", 32'(m_data0), 32'(11));
    chk("avg_ch1", 32'(m_data1), 32'(21));
    chk("after_pop_level", 32'(level), 32'(1));
    chk("start_period_a", 32'(start_cyc[1] - start_cyc[0]), 32'(P));
    chk("start_period_b", 32'(start_cyc[7] - start_cyc[6]), 32'(P));
    chk("no_late", 32'(err_late), 32'(0));

    // Fill past capacity with the consumer stalled
    base = n_avg;
    to = 0;
    while (n_avg < base + 9 && to < 3000) begin step(); to++; end
    chk("wait_fill", 32'(to < 3000), 32'(1));
    chk("full_level", 32'(level), 32'(DEPTH));
    chk("full_ovf", 32'(err_ovf), 32'(1));
    chk("full_head", 32'(m_data0), 32'(11));
    to = 0;
    while (!(drdy === 1'b1 && g0.size() == AVG_N - 1) && to < 400) begin step(); to++; end
    chk("wait_full_push", 32'(to < 400), 32'(1));
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("full_pop_push_level", 32'(level), 32'(DEPTH));

    // Slow engine: conversions outlast the period
    m_ready = 1'b1;
    eng_lat = 50;
    k = start_cyc.size();
    to = 0;
    while (start_cyc.size() < k + 3 && to < 600) begin step(); to++; end
    chk("wait_late_starts", 32'(to < 600), 32'(1));
    chk("late_start_gap_a", 32'(start_cyc[k + 1] - start_cyc[k]), 32'(2 * P));
    chk("late_start_gap_b", 32'(start_cyc[k + 2] - start_cyc[k + 1]), 32'(2 * P));
    chk("late_flag", 32'(err_late), 32'(1));
    eng_lat = 20;
    k2 = start_cyc.size();
    to = 0;
    while (start_cyc.size() < k2 + 2 && to < 400) begin step(); to++; end
    chk("wait_recover", 32'(to < 400), 32'(1));
    chk("recover_gap", 32'(start_cyc[k2 + 1] - start_cyc[k2]), 32'(P));
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_late", 32'(err_late), 32'(0));
    chk("clr_ovf", 32'(err_ovf), 32'(0));

    // Disable during the third conversion of a block
    to = 0;
    while (!(g0.size() == 2 && busy === 1'b1) && to < 400) begin step(); to++; end
    chk("wait_third_conv", 32'(to < 400), 32'(1));
    enable = 1'b0;
    to = 0;
    while (busy === 1'b1 && to < 100) begin step(); to++; end
    chk("wait_drain_conv", 32'(to < 100), 32'(1));
    k = start_cyc.size();
    repeat (120) step();
    chk("no_start_disabled", 32'(start_cyc.size()), 32'(k));
    chk("no_partial_push", 32'(level), 32'(0));
    m_ready = 1'b0;
    din_q.push_back({16'd100, 16'd200});
    din_q.push_back({16'd101, 16'd201});
    din_q.push_back({16'd102, 16'd202});
    din_q.push_back({16'd105, 16'd205});
    enable = 1'b1;
    base = n_avg;
    to = 0;
    while (n_avg == base && to < 400) begin step(); to++; end
    chk("wait_fresh_avg", 32'(to < 400), 32'(1));
    chk("fresh_ch0", 32'(m_data0), 32'(102));
    chk("fresh_ch1", 32'(m_data1), 32'(202));
    chk("fresh_level", 32'(level), 32'(1));

    // Reset in the middle of a conversion
    to = 0;
    while (busy !== 1'b1 && to < 100) begin step(); to++; end
    chk("wait_busy", 32'(to < 100), 32'(1));
    model_take = 1'b0;
    enable = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_start", 32'(start), 32'(0));
    chk("mid_rst_m_valid", 32'(m_valid), 32'(0));
    chk("mid_rst_m_data0", 32'(m_data0), 32'(0));
    chk("mid_rst_m_data1", 32'(m_data1), 32'(0));
    chk("mid_rst_level", 32'(level), 32'(0));
    chk("mid_rst_err_late", 32'(err_late), 32'(0));
    chk("mid_rst_err_ovf", 32'(err_ovf), 32'(0));
    to = 0;
    while (busy === 1'b1 && to < 100) begin step(); to++; end
    chk("wait_orphan_drdy", 32'(to < 100), 32'(1));
    step();
    step();
    rst = 1'b1;
    model_take = 1'b1;
    step();
    chk("orphan_drdy_level", 32'(level), 32'(0));

    // Flush coinciding with a push
    enable = 1'b1;
    base = n_avg;
    to = 0;
    while (n_avg == base && to < 400) begin step(); to++; end
    chk("wait_pre_flush", 32'(to < 400), 32'(1));
    to = 0;
    while (!(drdy === 1'b1 && g0.size() == AVG_N - 1) && to < 400) begin step(); to++; end
    chk("wait_flush_push", 32'(to < 400), 32'(1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_level", 32'(level), 32'(0));
    chk("flush_m_valid", 32'(m_valid), 32'(0));
    chk("flush_ovf", 32'(err_ovf), 32'(0));
    enable = 1'b0;
    repeat (50) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
